// File: rtl/adam_axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the memory-bridge FSM state type.
package adam_axil_pkg;

  localparam int unsigned AXIL_RESP_W = 2;

  localparam logic [AXIL_RESP_W-1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [AXIL_RESP_W-1:0] AXIL_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_RESP = 3'd3,
    PAUSED  = 3'd4
  } axil_mem_state_t;

endpackage

// File: rtl/adam_axil_mem_bridge_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface adam_axil_mem_bridge_if
  import adam_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic                   aw_valid;
  logic                   aw_ready;

  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_WIDTH-1:0]  w_strb;
  logic                   w_valid;
  logic                   w_ready;

  logic [AXIL_RESP_W-1:0] b_resp;
  logic                   b_valid;
  logic                   b_ready;

  logic [ADDR_WIDTH-1:0]  ar_addr;
  logic                   ar_valid;
  logic                   ar_ready;

  logic [DATA_WIDTH-1:0]  r_data;
  logic [AXIL_RESP_W-1:0] r_resp;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready,
           r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
           ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready,
           r_data, r_resp, r_valid
  );

endinterface

// File: rtl/adam_axil_mem_bridge.sv
// AXI-Lite slave serialising reads/writes onto a one-cycle-latency single-port SRAM.
// Optional out-of-range SLVERR responses: define ADAM_AXIL_MEM_BRIDGE_SLVERR_EN.
module adam_axil_mem_bridge
  import adam_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 4096,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MEM_AW     = $clog2(MEM_SIZE / STRB_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test,
  input  logic                  pause_req,
  output logic                  pause_ack,
  adam_axil_mem_bridge_if.slave axil,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned BYTE_AW = $clog2(MEM_SIZE);
  localparam int unsigned OFF_W   = $clog2(STRB_WIDTH);

  axil_mem_state_t       r_state, w_state_nxt;
  logic                  r_last_wr, w_last_wr_nxt;
  logic                  r_err, w_err_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

  logic w_wr_cand, w_rd_cand;
  logic w_aw_oor, w_ar_oor;
  logic w_aw_ready, w_w_ready, w_ar_ready;
  logic w_mem_req, w_mem_we, w_sel_wr;
  logic w_unused_bits;

  assign w_wr_cand = axil.aw_valid && axil.w_valid;
  assign w_rd_cand = axil.ar_valid;

`ifdef ADAM_AXIL_MEM_BRIDGE_SLVERR_EN
  // Any address bit above the memory window marks the access out of range.
  assign w_aw_oor      = |axil.aw_addr[ADDR_WIDTH-1:BYTE_AW];
  assign w_ar_oor      = |axil.ar_addr[ADDR_WIDTH-1:BYTE_AW];
  assign axil.b_resp   = r_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  assign axil.r_resp   = r_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
  assign w_unused_bits = ^{test, axil.aw_addr[OFF_W-1:0], axil.ar_addr[OFF_W-1:0]};
`else
  // Upper address bits alias onto the memory window.
  assign w_aw_oor      = 1'b0;
  assign w_ar_oor      = 1'b0;
  assign axil.b_resp   = AXIL_RESP_OKAY;
  assign axil.r_resp   = AXIL_RESP_OKAY;
  assign w_unused_bits = ^{test, axil.aw_addr[OFF_W-1:0], axil.ar_addr[OFF_W-1:0],
                           axil.aw_addr[ADDR_WIDTH-1:BYTE_AW],
                           axil.ar_addr[ADDR_WIDTH-1:BYTE_AW]};
`endif

  // Next-state, round-robin grant and grant-cycle memory strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_wr_nxt = r_last_wr;
    w_err_nxt     = r_err;
    w_rdata_nxt   = r_rdata;
    w_aw_ready    = 1'b0;
    w_w_ready     = 1'b0;
    w_ar_ready    = 1'b0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_sel_wr      = 1'b0;

    case (r_state)
      IDLE: begin
        if (pause_req) begin
          w_state_nxt = PAUSED;
        end else if (w_wr_cand && (!w_rd_cand || !r_last_wr)) begin
          w_aw_ready    = 1'b1;
          w_w_ready     = 1'b1;
          w_mem_req     = !w_aw_oor;
          w_mem_we      = 1'b1;
          w_sel_wr      = 1'b1;
          w_last_wr_nxt = 1'b1;
          w_err_nxt     = w_aw_oor;
          w_state_nxt   = WR_RESP;
        end else if (w_rd_cand) begin
          w_ar_ready    = 1'b1;
          w_mem_req     = !w_ar_oor;
          w_last_wr_nxt = 1'b0;
          w_err_nxt     = w_ar_oor;
          w_state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_rdata_nxt = r_err ? '0 : mem_rdata;
        w_state_nxt = RD_RESP;
      end
      RD_RESP: if (axil.r_ready) w_state_nxt = IDLE;
      WR_RESP: if (axil.b_ready) w_state_nxt = IDLE;
      PAUSED:  if (!pause_req)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last_wr <= 1'b1;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_wr <= w_last_wr_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign axil.aw_ready = w_aw_ready;
  assign axil.w_ready  = w_w_ready;
  assign axil.ar_ready = w_ar_ready;
  assign axil.b_valid  = (r_state == WR_RESP);
  assign axil.r_valid  = (r_state == RD_RESP);
  assign axil.r_data   = r_rdata;
  assign pause_ack     = (r_state == PAUSED);

  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_we;
  assign mem_addr  = w_sel_wr ? axil.aw_addr[BYTE_AW-1:OFF_W] : axil.ar_addr[BYTE_AW-1:OFF_W];
  assign mem_be    = w_sel_wr ? axil.w_strb : '0;
  assign mem_wdata = axil.w_data;

endmodule

// File: tb/tb_adam_axil_mem_bridge.sv
// Scoreboard bench for adam_axil_mem_bridge: directed scenarios plus randomized traffic
// against a byte-level memory reference model.
module tb_adam_axil_mem_bridge;

  localparam int unsigned MEM_SIZE = 4096;
  localparam int unsigned NWORDS   = MEM_SIZE / 4;
  localparam int          BUDGET   = 200;
`ifdef ADAM_AXIL_MEM_BRIDGE_SLVERR_EN
  localparam bit SLV_EN = 1'b1;
`else
  localparam bit SLV_EN = 1'b0;
`endif

  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        test;
  logic        pause_req;
  logic        pause_ack;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  adam_axil_mem_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axil ();

  adam_axil_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .test(test), .pause_req(pause_req), .pause_ack(pause_ack),
    .axil(axil), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          ntests = 0;
  int          nfail  = 0;
  exp_t        exp_q[$];
  byte         grant_log[$];
  int          mem_req_cnt = 0;
  logic [31:0] ref_words [NWORDS];
  logic [31:0] sram [NWORDS];
  logic [9:0]  last_wr_addr;
  logic [3:0]  last_wr_be;
  bit          rand_ready = 1'b0;
  bit          b_ready_force = 1'b1;
  bit          r_ready_force = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference memory: byte-merge writes, range rules decided from the byte address.
  function automatic logic [1:0] ref_write(input logic [31:0] addr, input logic [31:0] data,
                                           input logic [3:0] strb);
    int unsigned idx = (addr % MEM_SIZE) / 4;
    if (SLV_EN && addr >= MEM_SIZE) return 2'b10;
    for (int i = 0; i < 4; i++)
      if (strb[i]) ref_words[idx][8*i +: 8] = data[8*i +: 8];
    return 2'b00;
  endfunction

  function automatic exp_t ref_read(input logic [31:0] addr);
    exp_t e;
    e.is_rd = 1'b1;
    if (SLV_EN && addr >= MEM_SIZE) begin
      e.resp = 2'b10;
      e.data = 32'h0;
    end else begin
      e.resp = 2'b00;
      e.data = ref_words[(addr % MEM_SIZE) / 4];
    end
    return e;
  endfunction

  // Single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        last_wr_addr <= mem_addr;
        last_wr_be   <= mem_be;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always begin
    @(negedge clk);
    axil.b_ready = rand_ready ? 1'($urandom_range(0, 1)) : b_ready_force;
    axil.r_ready = rand_ready ? 1'($urandom_range(0, 1)) : r_ready_force;
  end

  // Monitor: sampled just before each rising edge.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_rdata;
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("r_hold_valid", 64'(axil.r_valid), 64'd1);
        chk("r_hold_data", 64'(axil.r_data), 64'(prev_rdata));
      end
      prev_hold  = axil.r_valid && !axil.r_ready;
      prev_rdata = axil.r_data;
      if (axil.aw_ready || axil.w_ready)
        chk("aw_w_ready_pair", 64'(axil.aw_ready), 64'(axil.w_ready));
      if (mem_req) begin
        mem_req_cnt++;
        chk("mem_req_only_on_grant", 64'(axil.ar_ready || axil.aw_ready), 64'd1);
      end
      if (pause_ack)
        chk("paused_quiet", 64'({axil.ar_ready, axil.aw_ready, axil.w_ready, mem_req}), 64'd0);
      if (axil.ar_ready && axil.aw_ready)
        chk("single_grant", 64'd2, 64'd1);
      if (axil.ar_ready) grant_log.push_back(8'h52);
      if (axil.aw_ready && axil.w_ready) grant_log.push_back(8'h57);
      if (axil.b_valid && axil.b_ready) begin
        if (exp_q.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("b_order", 64'(e.is_rd), 64'd0);
          chk("b_resp", 64'(axil.b_resp), 64'(e.resp));
        end
      end
      if (axil.r_valid && axil.r_ready) begin
        if (exp_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("r_order", 64'(e.is_rd), 64'd1);
          chk("r_resp", 64'(axil.r_resp), 64'(e.resp));
          chk("r_data", 64'(axil.r_data), 64'(e.data));
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   n = 0;
    bit   hs = 1'b0;
    e.is_rd = 1'b0;
    e.resp  = ref_write(addr, data, strb);
    e.data  = 32'h0;
    exp_q.push_back(e);
    @(negedge clk);
    axil.aw_addr = addr; axil.w_data = data; axil.w_strb = strb;
    axil.aw_valid = 1'b1; axil.w_valid = 1'b1;
    while (!hs && n < BUDGET) begin
      #1; hs = axil.aw_ready && axil.w_ready;
      @(negedge clk); n++;
    end
    axil.aw_valid = 1'b0; axil.w_valid = 1'b0;
    if (!hs) begin
      chk("write_timeout", 64'd1, 64'd0);
      void'(exp_q.pop_back());
    end else begin
      #1; chk("b_latency", 64'(axil.b_valid), 64'd1);
    end
  endtask

  task automatic do_read(input logic [31:0] addr);
    int n = 0;
    bit hs = 1'b0;
    exp_q.push_back(ref_read(addr));
    @(negedge clk);
    axil.ar_addr = addr; axil.ar_valid = 1'b1;
    while (!hs && n < BUDGET) begin
      #1; hs = axil.ar_ready;
      @(negedge clk); n++;
    end
    axil.ar_valid = 1'b0;
    if (!hs) begin
      chk("read_timeout", 64'd1, 64'd0);
      void'(exp_q.pop_back());
    end else begin
      #1; chk("r_latency_n1", 64'(axil.r_valid), 64'd0);
      @(negedge clk); #1;
      chk("r_latency_n2", 64'(axil.r_valid), 64'd1);
    end
  endtask

  initial begin
    int n;
    int cnt0;
    logic [31:0] a, d;
    rst = 1'b0; test = 1'b0; pause_req = 1'b0;
    axil.aw_valid = 1'b0; axil.w_valid = 1'b0; axil.ar_valid = 1'b0;
    axil.aw_addr = '0; axil.ar_addr = '0; axil.w_data = '0; axil.w_strb = '0;
    for (int i = 0; i < NWORDS; i++) ref_words[i] = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'({axil.aw_ready, axil.w_ready, axil.ar_ready}), 64'd0);
    chk("rst_b_valid", 64'(axil.b_valid), 64'd0);
    chk("rst_r_valid", 64'(axil.r_valid), 64'd0);
    chk("rst_resps", 64'({axil.b_resp, axil.r_resp}), 64'd0);
    chk("rst_r_data", 64'(axil.r_data), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_pause_ack", 64'(pause_ack), 64'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_word_addr", 64'(last_wr_addr), 64'd4);
    chk("wr_word_be", 64'(last_wr_be), 64'hF);
    do_read(32'h10);

    do_write(32'h20, 32'h11223344, 4'hF);
    do_write(32'h20, 32'h0000AB00, 4'h2);
    do_read(32'h20);

    r_ready_force = 1'b0;
    do_read(32'h10);
    fork
      do_read(32'h20);
      begin
        repeat (5) begin
          @(negedge clk); #2;
          chk("rresp_no_ar_ready", 64'(axil.ar_ready), 64'd0);
        end
        r_ready_force = 1'b1;
      end
    join

    b_ready_force = 1'b0;
    do_write(32'h40, 32'h55AA55AA, 4'hF);
    pause_req = 1'b1;
    repeat (3) begin @(negedge clk); #1; chk("pause_deferred", 64'(pause_ack), 64'd0); end
    b_ready_force = 1'b1;
    n = 0;
    while (!pause_ack && n < 10) begin @(negedge clk); #1; n++; end
    chk("pause_ack_rise", 64'(pause_ack), 64'd1);
    chk("pause_after_b", 64'(exp_q.size()), 64'd0);
    fork
      do_read(32'h40);
      begin
        repeat (4) begin
          @(negedge clk); #2;
          chk("paused_no_ar_ready", 64'(axil.ar_ready), 64'd0);
        end
        pause_req = 1'b0;
        @(negedge clk); #2;
        chk("unpause_ack", 64'(pause_ack), 64'd0);
      end
    join

    // Reset while the read sits in RD_WAIT: no response may follow.
    do_write(32'h200, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    axil.ar_addr = 32'h200; axil.ar_valid = 1'b1;
    n = 0;
    while (!axil.ar_ready && n < BUDGET) begin #1; if (!axil.ar_ready) begin @(negedge clk); n++; end end
    @(negedge clk);
    axil.ar_valid = 1'b0; rst = 1'b0;
    #1;
    chk("rst_mid_r_valid", 64'(axil.r_valid), 64'd0);
    chk("rst_mid_r_data", 64'(axil.r_data), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_resp", 64'(axil.r_valid), 64'd0);

    // Contended AR + AW/W: grants must alternate, read first.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) exp_q.push_back(ref_read(32'h200));
      else begin
        exp_t e;
        e.is_rd = 1'b0; e.data = 32'h0;
        e.resp = ref_write(32'h204, 32'h12345678, 4'hF);
        exp_q.push_back(e);
      end
    end
    grant_log.delete();
    @(negedge clk);
    axil.ar_addr = 32'h200; axil.aw_addr = 32'h204;
    axil.w_data = 32'h12345678; axil.w_strb = 4'hF;
    axil.ar_valid = 1'b1; axil.aw_valid = 1'b1; axil.w_valid = 1'b1;
    n = 0;
    while (grant_log.size() < 8 && n < BUDGET) begin @(negedge clk); n++; end
    axil.ar_valid = 1'b0; axil.aw_valid = 1'b0; axil.w_valid = 1'b0;
    chk("contend_grant_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      chk($sformatf("contend_grant_%0d", k), 64'(grant_log[k]), (k % 2 == 0) ? 64'h52 : 64'h57);
    repeat (4) @(negedge clk);

    for (int w = 0; w < 32; w++) do_write(32'(w * 4), $urandom, 4'hF);

    // Out-of-range read: SLVERR without touching memory, or alias onto word 0.
    cnt0 = mem_req_cnt;
    do_read(32'h1000);
    chk("oor_read_mem_req", 64'(mem_req_cnt - cnt0), SLV_EN ? 64'd0 : 64'd1);

    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, 4'($urandom_range(0, 15)));
      else do_read(a);
    end
    rand_ready = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", ntests, nfail);
    $fatal(1, "watchdog");
  end

endmodule
